core_mem_arbiter: RTL
=====================

# core_mem_arbiter

Round-robin memory arbiter between the NO_OF_CORES compute cores and the single-port shared data RAM. Each core issues independent read/write requests. The arbiter grants one access per cycle to the RAM port and routes read data back to the requesting core. Identical-address reads from several cores in the same cycle are coalesced into one RAM access and answered together. It replaces the combinational AND/OR merging of core read/write strobes at the processor top level.

## Interface
Parameters:
- NO_OF_CORES, 6, number of requesting cores (2..8)
- DATA_LEN, 16, data word width
- ADDRESS_LEN, 12, RAM word address width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NO_OF_CORES  bit c: core c has a pending request
- req_write  in  NO_OF_CORES  bit c: 1 = write, 0 = read
- req_addr  in  ADDRESS_LEN*NO_OF_CORES  core c address at [ADDRESS_LEN*c +: ADDRESS_LEN]
- req_wdata  in  DATA_LEN*NO_OF_CORES  core c write data at [DATA_LEN*c +: DATA_LEN]
- grant  out  NO_OF_CORES  combinational; bit c high = core c request accepted at this edge
- rsp_valid  out  NO_OF_CORES  registered; bit c high = rsp_rdata is core c read data
- rsp_rdata  out  DATA_LEN  shared read-return bus (mem_rdata passthrough)
- mem_en  out  1  registered RAM access strobe
- mem_we  out  1  registered RAM write enable
- mem_addr  out  ADDRESS_LEN  registered RAM address
- mem_wdata  out  DATA_LEN  registered RAM write data
- mem_rdata  in  DATA_LEN  RAM read data, valid one cycle after mem_en with mem_we=0
- busy  out  1  registered; high while any access or read return is in flight

## Operation
- State: rr_ptr (index of highest-priority core), one-entry issue stage (mem_*), one-entry return stage (rsp_mask, NO_OF_CORES bits).
- Winner selection each cycle: first c with req_valid[c]=1, searching rr_ptr, rr_ptr+1, …, wrapping NO_OF_CORES-1 → 0.
- Winner is a write: grant only the winner. Writes are never coalesced.
- Winner is a read: grant the winner plus every core d with req_valid[d]=1, req_write[d]=0 and req_addr slice d == winner address.
- At the accepting edge:
  - mem_en←1; mem_we, mem_addr, mem_wdata ← winner fields.
  - rr_ptr ← (winner+1) mod NO_OF_CORES. Only the winner moves the pointer, never coalesced cores.
- No request at an edge: mem_en←0, mem_we←0; mem_addr and mem_wdata hold; rr_ptr holds.
- Return stage: at each edge, rsp_mask ← the grant vector if the issued access was a read, else 0. rsp_valid = rsp_mask.
- Core contract: hold req_valid/req_write/req_addr/req_wdata stable until grant is seen. A core that keeps req_valid high in the cycle after its grant is presenting a new request.
- busy = mem_en | (|rsp_mask).
- Accesses reach the RAM in grant order. A write granted at T followed by a read of the same address granted at T+1 returns the written value.

## Timing
- Reset values: grant=0 (forced low while reset=1), rsp_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, rr_ptr=0.
- Reset mid-operation discards any in-flight read; no rsp_valid is produced for it afterwards.
- Read grant in cycle T → mem_en in T+1 → rsp_valid/rsp_rdata in T+2. Read latency is 2 cycles from grant.
- Write grant in T → mem_en=mem_we=1 in T+1. No response is produced.
- Throughput: one RAM access per cycle. A single persistent requester is granted every cycle.
- Fairness: with all NO_OF_CORES requesting continuously, each core is granted exactly once per NO_OF_CORES cycles.
- grant depends combinationally on req_* and rr_ptr only. There is no combinational path from mem_rdata to grant.

## Test plan
- Reset then single read: core 2 reads addr 0x005 holding 0x1234 → grant=6'b000100 in T, mem_en/mem_addr=0x005 in T+1, rsp_valid=6'b000100 with rsp_rdata=0x1234 in T+2.
- All 6 cores request writes continuously from rr_ptr=0 → grants in order 0,1,2,3,4,5,0 on consecutive cycles; the pointer wraps from 5 to 0.
- Coalescing: cores 1, 3, 4 read addr 0x017 and core 5 reads 0x018 in the same cycle, rr_ptr=0 → grant=6'b011010 in one cycle, one RAM access, rsp_valid=6'b011010 two cycles later; core 5 granted the next cycle.
- Mixed: core 0 writes 0x00A=0xBEEF and core 1 reads 0x00A in the same cycle → core 1 not coalesced; core 1 granted at T+1 and receives 0xBEEF.
- Reset asserted the cycle after a read grant → no rsp_valid ever appears; all outputs are 0 during and after reset; rr_ptr=0.
- Idle: req_valid=0 for 10 cycles → mem_en=0, busy=0, rsp_valid=0 and rr_ptr unchanged throughout.

Source files
------------

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_mem_arbiter : round-robin arbiter from NO_OF_CORES cores to one RAM port,
//                    coalescing same-address reads into a single access.
// Revision 1.0
// ---------------------------------------------------------------------------
module core_mem_arbiter #(
   parameter int NO_OF_CORES = 6,
   parameter int DATA_LEN    = 16,
   parameter int ADDRESS_LEN = 12
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NO_OF_CORES-1:0]           req_valid,
   input  logic [NO_OF_CORES-1:0]           req_write,
   input  logic [ADDRESS_LEN*NO_OF_CORES-1:0] req_addr,
   input  logic [DATA_LEN*NO_OF_CORES-1:0]  req_wdata,
   output logic [NO_OF_CORES-1:0]           grant,
   output logic [NO_OF_CORES-1:0]           rsp_valid,
   output logic [DATA_LEN-1:0]              rsp_rdata,
   output logic                             mem_en,
   output logic                             mem_we,
   output logic [ADDRESS_LEN-1:0]           mem_addr,
   output logic [DATA_LEN-1:0]              mem_wdata,
   input  logic [DATA_LEN-1:0]              mem_rdata,
   output logic                             busy
);

   localparam int PTR_W = $clog2(NO_OF_CORES);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NO_OF_CORES - 1);

   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       win_idx;
   logic [PTR_W:0]         scan;
   logic                   win_found;
   logic                   win_write;
   logic [ADDRESS_LEN-1:0] win_addr;
   logic [DATA_LEN-1:0]    win_wdata;
   logic [NO_OF_CORES-1:0] issue_mask;
   logic [NO_OF_CORES-1:0] rsp_mask;

   // First valid requester at or after rr_ptr, wrapping past the last core.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan      = '0;
      for (int i = 0; i < NO_OF_CORES; i++) begin
         scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (scan >= (PTR_W+1)'(NO_OF_CORES))
            scan = scan - (PTR_W+1)'(NO_OF_CORES);
         if (!win_found && req_valid[scan[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      win_write = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int d = 0; d < NO_OF_CORES; d++) begin
         if (win_idx == PTR_W'(d)) begin
            win_write = req_write[d];
            win_addr  = req_addr[ADDRESS_LEN*d +: ADDRESS_LEN];
            win_wdata = req_wdata[DATA_LEN*d +: DATA_LEN];
         end
      end
   end

   // A read winner drags along every other reader of the same address.
   always_comb begin
      grant = '0;
      if (!reset && win_found) begin
         for (int d = 0; d < NO_OF_CORES; d++) begin
            if (win_write)
               grant[d] = (win_idx == PTR_W'(d));
            else
               grant[d] = req_valid[d] && !req_write[d] &&
                          (req_addr[ADDRESS_LEN*d +: ADDRESS_LEN] == win_addr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr     <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         issue_mask <= '0;
         rsp_mask   <= '0;
      end else begin
         rsp_mask   <= (mem_en && !mem_we) ? issue_mask : '0;
         issue_mask <= grant;
         if (win_found) begin
            mem_en    <= 1'b1;
            mem_we    <= win_write;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            rr_ptr    <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
         end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
         end
      end
   end

   assign rsp_valid = rsp_mask;
   assign rsp_rdata = mem_rdata;
   assign busy      = mem_en | (|rsp_mask);

endmodule
`default_nettype wire
